// File: rtl/rob_if.sv
// Dispatch / writeback / retirement bundle between the reorder buffer and its neighbours.
interface rob_if #(
  parameter int ROB_WIDTH = 3,
  parameter int REG_WIDTH = 5
);
  logic                 issue_req;
  logic [REG_WIDTH-1:0] issue_arch_num;
  logic                 issue_ready;
  logic                 issue;
  logic [ROB_WIDTH-1:0] issue_tag;
  logic                 wb_valid;
  logic [ROB_WIDTH-1:0] wb_tag;
  logic [31:0]          wb_data;
  logic                 flush;
  logic                 commit;
  logic [REG_WIDTH-1:0] commit_arch_num;
  logic [ROB_WIDTH-1:0] commit_tag;
  logic [31:0]          commit_data;
  logic                 rf_reset;
  logic [ROB_WIDTH:0]   count;

  modport master (
    output issue_req, issue_arch_num, wb_valid, wb_tag, wb_data, flush,
    input  issue_ready, issue, issue_tag, commit, commit_arch_num, commit_tag,
           commit_data, rf_reset, count
  );

  modport slave (
    input  issue_req, issue_arch_num, wb_valid, wb_tag, wb_data, flush,
    output issue_ready, issue, issue_tag, commit, commit_arch_num, commit_tag,
           commit_data, rf_reset, count
  );
endinterface

// File: rtl/rob_controller.sv
// In-order reorder buffer: allocates tags at dispatch, captures CDB results, retires from head.
// Optional feature macro ROB_WB_BYPASS_EN: a writeback to the head retires in the same cycle.
module rob_controller #(
  parameter int ROB_WIDTH = 3,
  parameter int REG_WIDTH = 5
) (
  input  logic   clk,
  input  logic   reset,
  rob_if.slave   rob
);

  localparam int                 DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL  = (ROB_WIDTH + 1)'(DEPTH);

  logic [DEPTH-1:0]     busy_q;
  logic [DEPTH-1:0]     done_q;
  logic [REG_WIDTH-1:0] arch_q [DEPTH];
  logic [31:0]          data_q [DEPTH];
  logic [ROB_WIDTH-1:0] head_q;
  logic [ROB_WIDTH-1:0] tail_q;
  logic [ROB_WIDTH:0]   count_q;

  logic                 head_busy;
  logic                 head_done;
  logic                 wb_accept;
  logic                 issue_ready_c;
  logic                 issue_c;
  logic                 commit_c;
  logic [31:0]          commit_data_c;
`ifdef ROB_WB_BYPASS_EN
  logic                 bypass_c;
`endif

  always_comb begin
    head_busy     = busy_q[head_q];
    head_done     = done_q[head_q];
    wb_accept     = rob.wb_valid && busy_q[rob.wb_tag] && !done_q[rob.wb_tag];
    // Fullness uses the registered count only, so a same-cycle commit never frees a slot.
    issue_ready_c = reset && !rob.flush && (count_q < FULL);
    issue_c       = rob.issue_req && issue_ready_c;
`ifdef ROB_WB_BYPASS_EN
    bypass_c      = wb_accept && (rob.wb_tag == head_q);
    commit_c      = reset && !rob.flush && head_busy && (head_done || bypass_c);
    commit_data_c = head_done ? data_q[head_q] : rob.wb_data;
`else
    commit_c      = reset && !rob.flush && head_busy && head_done;
    commit_data_c = data_q[head_q];
`endif
  end

  assign rob.issue_ready     = issue_ready_c;
  assign rob.issue           = issue_c;
  assign rob.issue_tag       = tail_q;
  assign rob.commit          = commit_c;
  assign rob.commit_tag      = head_q;
  assign rob.commit_arch_num = arch_q[head_q];
  assign rob.commit_data     = commit_data_c;
  assign rob.rf_reset        = rob.flush || !reset;
  assign rob.count           = count_q;

  // Control state: pointers, occupancy and per-entry status bits.
  always_ff @(posedge clk) begin
    if (!reset || rob.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
    end else begin
      if (wb_accept) begin
        done_q[rob.wb_tag] <= 1'b1;
      end
      // Retire after the writeback update so a bypassed head leaves with done clear.
      if (commit_c) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + ROB_WIDTH'(1);
      end
      if (issue_c) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + ROB_WIDTH'(1);
      end
      case ({issue_c, commit_c})
        2'b10:   count_q <= count_q + (ROB_WIDTH + 1)'(1);
        2'b01:   count_q <= count_q - (ROB_WIDTH + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage is never reset; busy/done decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (wb_accept) begin
      data_q[rob.wb_tag] <= rob.wb_data;
    end
    if (issue_c) begin
      arch_q[tail_q] <= rob.issue_arch_num;
    end
  end

endmodule

// File: tb/tb_rob_controller.sv
// Directed bench for rob_controller (DEPTH=8); optional bypass scenario under ROB_WB_BYPASS_EN.
module tb_rob_controller;

  localparam int RW = 3;
  localparam int GW = 5;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  rob_if #(.ROB_WIDTH(RW), .REG_WIDTH(GW)) rob_bus ();

  rob_controller #(.ROB_WIDTH(RW), .REG_WIDTH(GW)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rob_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic req, input logic [GW-1:0] arch, input logic wbv,
                       input logic [RW-1:0] wbt, input logic [31:0] wbd, input logic fl);
    rob_bus.issue_req      = req;
    rob_bus.issue_arch_num = arch;
    rob_bus.wb_valid       = wbv;
    rob_bus.wb_tag         = wbt;
    rob_bus.wb_data        = wbd;
    rob_bus.flush          = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b0;
    drive(1'b1, 5'd3, 1'b0, 3'd0, 32'd0, 1'b0);
    @(posedge clk);
    step();

    // Held in reset: no handshakes, register file held in reset.
    drive(1'b1, 5'd3, 1'b0, 3'd0, 32'd0, 1'b0);
    check("rst_issue", 32'(rob_bus.issue), 32'd0);
    check("rst_ready", 32'(rob_bus.issue_ready), 32'd0);
    check("rst_commit", 32'(rob_bus.commit), 32'd0);
    check("rst_rf_reset", 32'(rob_bus.rf_reset), 32'd1);

    reset = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
    check("post_rst_count", 32'(rob_bus.count), 32'd0);
    check("post_rst_tag", 32'(rob_bus.issue_tag), 32'd0);
    check("post_rst_rf_reset", 32'(rob_bus.rf_reset), 32'd0);
    check("post_rst_ready", 32'(rob_bus.issue_ready), 32'd1);

    // Fill: r1..r8 receive tags 0..7.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, GW'(i + 1), 1'b0, 3'd0, 32'd0, 1'b0);
      check($sformatf("fill_issue%0d", i), 32'(rob_bus.issue), 32'd1);
      check($sformatf("fill_tag%0d", i), 32'(rob_bus.issue_tag), 32'(i));
      step();
    end
    drive(1'b1, 5'd9, 1'b0, 3'd0, 32'd0, 1'b0);
    check("full_count", 32'(rob_bus.count), 32'd8);
    check("full_ready", 32'(rob_bus.issue_ready), 32'd0);
    check("full_issue", 32'(rob_bus.issue), 32'd0);

`ifdef ROB_WB_BYPASS_EN
    // Writeback to the pending head retires in the same cycle with the broadcast data.
    drive(1'b0, 5'd0, 1'b1, 3'd0, 32'hDEADBEEF, 1'b0);
    check("byp_commit", 32'(rob_bus.commit), 32'd1);
    check("byp_data", rob_bus.commit_data, 32'hDEADBEEF);
    check("byp_tag", 32'(rob_bus.commit_tag), 32'd0);
    check("byp_arch", 32'(rob_bus.commit_arch_num), 32'd1);
    step();
    drive(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
    check("byp_count", 32'(rob_bus.count), 32'd7);
    check("byp_next_commit", 32'(rob_bus.commit), 32'd0);
`else
    // Out-of-order writebacks 2,1,0 retire in order 0,1,2.
    drive(1'b0, 5'd0, 1'b1, 3'd2, 32'h22, 1'b0);
    check("wb2_commit", 32'(rob_bus.commit), 32'd0);
    step();
    drive(1'b0, 5'd0, 1'b1, 3'd1, 32'h11, 1'b0);
    check("wb1_commit", 32'(rob_bus.commit), 32'd0);
    step();
    drive(1'b0, 5'd0, 1'b1, 3'd0, 32'h100, 1'b0);
    check("wb0_no_same_cycle", 32'(rob_bus.commit), 32'd0);
    step();

    // Full with done head: commit wins the slot, issue must wait a cycle.
    drive(1'b1, 5'd9, 1'b0, 3'd0, 32'd0, 1'b0);
    check("c0_commit", 32'(rob_bus.commit), 32'd1);
    check("c0_tag", 32'(rob_bus.commit_tag), 32'd0);
    check("c0_data", rob_bus.commit_data, 32'h100);
    check("c0_arch", 32'(rob_bus.commit_arch_num), 32'd1);
    check("c0_issue_blocked", 32'(rob_bus.issue), 32'd0);
    step();
    drive(1'b1, 5'd9, 1'b0, 3'd0, 32'd0, 1'b0);
    check("c1_count", 32'(rob_bus.count), 32'd7);
    check("wrap_issue", 32'(rob_bus.issue), 32'd1);
    check("wrap_tag", 32'(rob_bus.issue_tag), 32'd0);
    check("c1_commit", 32'(rob_bus.commit), 32'd1);
    check("c1_tag", 32'(rob_bus.commit_tag), 32'd1);
    check("c1_data", rob_bus.commit_data, 32'h11);
    step();
    drive(1'b0, 5'd0, 1'b1, 3'd3, 32'h33, 1'b0);
    check("c2_count", 32'(rob_bus.count), 32'd7);
    check("c2_tag", 32'(rob_bus.commit_tag), 32'd2);
    check("c2_data", rob_bus.commit_data, 32'h22);
    check("c2_arch", 32'(rob_bus.commit_arch_num), 32'd3);
    step();
    drive(1'b0, 5'd0, 1'b1, 3'd4, 32'h44, 1'b0);
    check("c3_commit", 32'(rob_bus.commit), 32'd1);
    check("c3_data", rob_bus.commit_data, 32'h33);
    check("c3_arch", 32'(rob_bus.commit_arch_num), 32'd4);
    step();
    drive(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
    check("pre_flush_count", 32'(rob_bus.count), 32'd5);
    check("pre_flush_head_ready", 32'(rob_bus.commit), 32'd1);
`endif

    // Flush: nothing retires or issues, register file reset, buffer emptied.
    drive(1'b1, 5'd2, 1'b0, 3'd0, 32'd0, 1'b1);
    check("flush_commit", 32'(rob_bus.commit), 32'd0);
    check("flush_issue", 32'(rob_bus.issue), 32'd0);
    check("flush_rf_reset", 32'(rob_bus.rf_reset), 32'd1);
    step();
    drive(1'b0, 5'd0, 1'b1, 3'd5, 32'h55, 1'b0);
    check("post_flush_count", 32'(rob_bus.count), 32'd0);
    check("post_flush_tag", 32'(rob_bus.issue_tag), 32'd0);
    check("post_flush_rf_reset", 32'(rob_bus.rf_reset), 32'd0);
    check("wb_free_commit", 32'(rob_bus.commit), 32'd0);
    step();

    // Writeback to a free entry left no trace.
    drive(1'b1, 5'd7, 1'b0, 3'd0, 32'd0, 1'b0);
    check("wb_free_count", 32'(rob_bus.count), 32'd0);
    check("wb_free_no_commit", 32'(rob_bus.commit), 32'd0);
    check("i7_tag", 32'(rob_bus.issue_tag), 32'd0);
    step();
    drive(1'b1, 5'd8, 1'b0, 3'd0, 32'd0, 1'b0);
    check("i8_tag", 32'(rob_bus.issue_tag), 32'd1);
    step();
    drive(1'b0, 5'd0, 1'b1, 3'd1, 32'hB1, 1'b0);
    check("wb_b1_commit", 32'(rob_bus.commit), 32'd0);
    step();
    drive(1'b0, 5'd0, 1'b1, 3'd1, 32'hBAD, 1'b0);
    check("dup_commit", 32'(rob_bus.commit), 32'd0);
    step();
`ifdef ROB_WB_BYPASS_EN
    drive(1'b0, 5'd0, 1'b1, 3'd0, 32'hA0, 1'b0);
    check("h0_commit", 32'(rob_bus.commit), 32'd1);
    check("h0_data", rob_bus.commit_data, 32'hA0);
    step();
`else
    drive(1'b0, 5'd0, 1'b1, 3'd0, 32'hA0, 1'b0);
    check("h0_wait", 32'(rob_bus.commit), 32'd0);
    step();
    drive(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
    check("h0_commit", 32'(rob_bus.commit), 32'd1);
    check("h0_data", rob_bus.commit_data, 32'hA0);
    check("h0_arch", 32'(rob_bus.commit_arch_num), 32'd7);
    step();
`endif
    drive(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
    check("h1_commit", 32'(rob_bus.commit), 32'd1);
    check("h1_tag", 32'(rob_bus.commit_tag), 32'd1);
    check("h1_data_not_dup", rob_bus.commit_data, 32'hB1);
    check("h1_arch", 32'(rob_bus.commit_arch_num), 32'd8);
    step();
    drive(1'b1, 5'd4, 1'b0, 3'd0, 32'd0, 1'b0);
    check("drain_count", 32'(rob_bus.count), 32'd0);
    check("drain_commit", 32'(rob_bus.commit), 32'd0);
    check("drain_tag", 32'(rob_bus.issue_tag), 32'd2);
    step();

    // Reset mid-stream overrides a concurrent flush and issue request.
    reset = 1'b0;
    drive(1'b1, 5'd4, 1'b0, 3'd0, 32'd0, 1'b1);
    check("mid_rst_issue", 32'(rob_bus.issue), 32'd0);
    check("mid_rst_ready", 32'(rob_bus.issue_ready), 32'd0);
    check("mid_rst_rf_reset", 32'(rob_bus.rf_reset), 32'd1);
    step();
    reset = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0);
    check("mid_rst_count", 32'(rob_bus.count), 32'd0);
    check("mid_rst_tag", 32'(rob_bus.issue_tag), 32'd0);
    check("mid_rst_commit", 32'(rob_bus.commit), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rob_controller.md
ROB_CONTROLLER -- requirements
Module: rob_controller

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 3, meaning log2 of ROB depth (DEPTH = 2**ROB_WIDTH entries).
REQ-002 SHALL have parameter REG_WIDTH, default 5, meaning architectural register number width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; reset==0 at a posedge resets the block.
REQ-005 SHALL have port issue_req  input  1  dispatch requests one ROB entry.
REQ-006 SHALL have port issue_arch_num  input  REG_WIDTH  destination register of the issuing instruction.
REQ-007 SHALL have port issue_ready  output  1  an entry is free.
REQ-008 SHALL have port issue  output  1  allocation accepted this cycle; drives register-file issue.
REQ-009 SHALL have port issue_tag  output  ROB_WIDTH  tag allocated (tail pointer); drives register-file issue_tag.
REQ-010 SHALL have ports wb_valid / wb_tag / wb_data  input  1 / ROB_WIDTH / 32  CDB result broadcast.
REQ-011 SHALL have port flush  input  1  discard all in-flight entries.
REQ-012 SHALL have ports commit / commit_arch_num / commit_tag / commit_data  output  1 / REG_WIDTH / ROB_WIDTH / 32  in-order retirement to the register file.
REQ-013 SHALL have port rf_reset  output  1  active-high register-file reset.
REQ-014 SHALL have port count  output  ROB_WIDTH+1  occupied entries, 0..DEPTH.

Function
REQ-015 SHALL keep a circular buffer of DEPTH entries {busy, done, arch_num, data}, with head, tail and count registers; pointers wrap from DEPTH-1 to 0.
REQ-016 SHALL drive issue_ready = (count < DEPTH) && !flush; a commit in the same cycle does not free a slot for that cycle's issue.
REQ-017 SHALL drive issue = issue_req && issue_ready and issue_tag = tail, both combinational; on issue, tail entry gets busy=1, done=0, arch_num=issue_arch_num, and tail increments.
REQ-018 SHALL, on wb_valid with entry wb_tag busy && !done, store wb_data and set done=1 at the next edge; writebacks to non-busy or already-done entries are ignored.
REQ-019 SHALL drive commit = head busy && head done && !flush combinationally, with commit_tag = head, commit_arch_num and commit_data from the head entry; when commit is high, the head entry gets busy=0 and head increments.
REQ-020 SHALL, without the bypass, commit an entry no earlier than one cycle after its writeback.
REQ-021 SHALL update count by +1 on issue only, -1 on commit only, and 0 on both or neither; count never exceeds DEPTH or underflows.
REQ-022 SHALL, on flush, force issue=0 and commit=0 that cycle, clear all busy/done bits, and set head=tail=count=0 at the next edge.
REQ-023 SHALL drive rf_reset = flush || !reset combinationally, so register-file valid bits are restored on the same edge.
REQ-024 SHALL allow issue, writeback and commit to occur in the same cycle, including to the same entry when wrap-around makes tail==head after commit.

Reset
REQ-025 SHALL, when reset==0, set head=tail=count=0 and clear all busy/done bits; arch_num and data are not reset.
REQ-026 SHALL hold issue=0, commit=0, issue_ready=0 and rf_reset=1 while reset==0, and reset SHALL override flush and in-flight operations mid-stream.
REQ-027 SHALL output count=0 and issue_tag=0 in the first cycle after reset is released.

Configuration
REQ-028 SHALL implement macro ROB_WB_BYPASS_EN: when defined, wb_valid with wb_tag==head on a busy, not-done head entry asserts commit in the same cycle with commit_data=wb_data, and the entry retires without setting done.
REQ-029 SHALL, when ROB_WB_BYPASS_EN is undefined, implement no bypass path, and commit SHALL depend only on registered state plus flush.

Verification
REQ-030 SHALL cover: reset released, 8 issues to r1..r8 with DEPTH=8 -> tags 0..7, count=8, issue_ready=0 on cycle 9.
REQ-031 SHALL cover: writebacks to tags 2,1,0 in consecutive cycles -> commits of tags 0,1,2 in order, starting the cycle after tag 0's writeback (bypass off).
REQ-032 SHALL cover: full ROB with head done, plus issue_req and commit in the same cycle -> commit=1, issue=0, count=7; the next cycle issue=1 with tag=0 (wrap).
REQ-033 SHALL cover: flush with 5 entries busy and the head done -> commit=0, rf_reset=1 that cycle; then count=0, issue_tag=0.
REQ-034 SHALL cover: writeback to a free tag 5, and a duplicate writeback to a done tag -> no state change, no extra commit.
REQ-035 SHALL cover: ROB_WB_BYPASS_EN defined, writeback of tag 0 with data 0xDEADBEEF at head -> commit=1 with commit_data=0xDEADBEEF in the same cycle.
